// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [3:0] RAM_BE_FULL = 4'hF;
  localparam int         WAIT_W      = 4;

  typedef logic [WAIT_W-1:0] wait_t;

endpackage

// File: rtl/ram_port_arbiter.sv
// Arbitrates the CV32E40P instruction and data OBI ports onto one single-port RAM,
// routing each 1-cycle-latency response back to the master that was granted.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int SIZE_WORDS = 1024,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_be_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  output logic [3:0]  ram_be_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_rvalid_i
);

  owner_e      owner_q;
  logic        oor_q;
  logic        we_q;
  wait_t       wait_q;
  logic [31:0] instr_rdata_q;
  logic [31:0] data_rdata_q;

  logic        instr_oor;
  logic        data_oor;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  assign instr_oor = instr_addr_i[31:2] >= 30'(SIZE_WORDS);
  assign data_oor  = data_addr_i[31:2]  >= 30'(SIZE_WORDS);

  always_comb begin
    instr_gnt_o = 1'b0;
    data_gnt_o  = 1'b0;
    if (!rst) begin
      if (instr_req_i && (!data_req_i || wait_q == wait_t'(MAX_WAIT))) begin
        instr_gnt_o = 1'b1;
      end else if (data_req_i) begin
        data_gnt_o = 1'b1;
      end
    end
  end

  // Out-of-range grants never reach the RAM; they are answered locally next cycle.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    if (instr_gnt_o && !instr_oor) begin
      ram_req_o  = 1'b1;
      ram_addr_o = instr_addr_i;
      ram_be_o   = RAM_BE_FULL;
    end else if (data_gnt_o && !data_oor) begin
      ram_req_o   = 1'b1;
      ram_we_o    = data_we_i;
      ram_addr_o  = data_addr_i;
      ram_wdata_o = data_wdata_i;
      ram_be_o    = data_be_i;
    end
  end

  assign resp_valid = oor_q | ram_rvalid_i;
  assign resp_rdata = (oor_q || we_q) ? '0 : ram_rdata_i;

  // rdata is live during the owner's response and otherwise replays the last delivered word.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = instr_rdata_q;
    data_rvalid_o  = 1'b0;
    data_err_o     = 1'b0;
    data_rdata_o   = data_rdata_q;
    unique case (owner_q)
      OWN_INSTR: begin
        instr_rvalid_o = resp_valid;
        instr_err_o    = oor_q;
        if (resp_valid) instr_rdata_o = resp_rdata;
      end
      OWN_DATA: begin
        data_rvalid_o = resp_valid;
        data_err_o    = oor_q;
        if (resp_valid) data_rdata_o = resp_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q       <= OWN_NONE;
      oor_q         <= 1'b0;
      we_q          <= 1'b0;
      wait_q        <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      instr_rdata_q <= instr_rdata_o;
      data_rdata_q  <= data_rdata_o;
      if (instr_gnt_o) begin
        owner_q <= OWN_INSTR;
        oor_q   <= instr_oor;
        we_q    <= 1'b0;
      end else if (data_gnt_o) begin
        owner_q <= OWN_DATA;
        oor_q   <= data_oor;
        we_q    <= data_we_i;
      end else begin
        owner_q <= OWN_NONE;
        oor_q   <= 1'b0;
        we_q    <= 1'b0;
      end
      if (!instr_req_i || instr_gnt_o) begin
        wait_q <= '0;
      end else if (wait_q != wait_t'(MAX_WAIT)) begin
        wait_q <= wait_q + wait_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a cycle-level reference model.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int SIZE_WORDS = 1024;
  localparam int MAX_WAIT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [3:0]  data_be_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_rdata_i;
  logic        ram_rvalid_i;

  int n_chk = 0;
  int n_err = 0;

  ram_port_arbiter #(.SIZE_WORDS(SIZE_WORDS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i),
    .ram_rvalid_i(ram_rvalid_i)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: read-before-write, response one cycle after req.
  logic [31:0] ram_mem [SIZE_WORDS];
  logic        ram_rv_q = 1'b0;
  logic [31:0] ram_rd_q = '0;
  logic        spur = 1'b0;
  assign ram_rvalid_i = ram_rv_q | spur;
  assign ram_rdata_i  = ram_rd_q;

  always @(posedge clk) begin
    ram_rv_q <= ram_req_o;
    if (ram_req_o) begin
      ram_rd_q <= ram_mem[ram_addr_o[11:2]];
      if (ram_we_o)
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[11:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] model_mem [SIZE_WORDS];
  int          m_wait = 0;
  int          m_who  = 0;   // pending response: 0 none, 1 instr, 2 data
  logic        m_err  = 1'b0;
  logic [31:0] m_data = '0;
  logic [31:0] m_ihold = '0, m_dhold = '0;

  always @(negedge clk) begin
    logic        e_ig, e_dg, e_oor, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_be;
    int          w;
    if (rst) begin
      chk("rst_igt", {31'b0, instr_gnt_o}, 0);
      chk("rst_dgt", {31'b0, data_gnt_o}, 0);
      chk("rst_ramreq", {31'b0, ram_req_o}, 0);
      chk("rst_irv", {31'b0, instr_rvalid_o}, 0);
      chk("rst_drv", {31'b0, data_rvalid_o}, 0);
      chk("rst_ierr", {31'b0, instr_err_o}, 0);
      chk("rst_derr", {31'b0, data_err_o}, 0);
      chk("rst_irdata", instr_rdata_o, 0);
      chk("rst_drdata", data_rdata_o, 0);
      m_wait = 0; m_who = 0; m_err = 1'b0; m_data = '0; m_ihold = '0; m_dhold = '0;
    end else begin
      e_ig   = instr_req_i && (!data_req_i || m_wait == MAX_WAIT);
      e_dg   = data_req_i && !e_ig;
      e_addr = e_ig ? instr_addr_i : data_addr_i;
      e_oor  = (e_ig || e_dg) && ({32'b0, e_addr} >= 64'(4 * SIZE_WORDS));
      e_req  = (e_ig || e_dg) && !e_oor;
      e_we   = e_req && e_dg && data_we_i;
      e_be   = !e_req ? 4'h0 : (e_ig ? 4'hF : data_be_i);
      e_wdata = (e_req && e_dg) ? data_wdata_i : 32'h0;
      chk("igt", {31'b0, instr_gnt_o}, {31'b0, e_ig});
      chk("dgt", {31'b0, data_gnt_o}, {31'b0, e_dg});
      chk("ram_req", {31'b0, ram_req_o}, {31'b0, e_req});
      chk("ram_we", {31'b0, ram_we_o}, {31'b0, e_we});
      chk("ram_addr", ram_addr_o, e_req ? e_addr : 32'h0);
      chk("ram_be", {28'b0, ram_be_o}, {28'b0, e_be});
      chk("ram_wdata", ram_wdata_o, e_wdata);
      if (m_who == 1) m_ihold = m_data;
      if (m_who == 2) m_dhold = m_data;
      chk("irv", {31'b0, instr_rvalid_o}, (m_who == 1) ? 32'd1 : 32'd0);
      chk("drv", {31'b0, data_rvalid_o}, (m_who == 2) ? 32'd1 : 32'd0);
      chk("ierr", {31'b0, instr_err_o}, {31'b0, (m_who == 1) && m_err});
      chk("derr", {31'b0, data_err_o}, {31'b0, (m_who == 2) && m_err});
      chk("irdata", instr_rdata_o, m_ihold);
      chk("drdata", data_rdata_o, m_dhold);
      // advance to the next cycle
      w      = int'(e_addr[11:2]);
      m_who  = e_ig ? 1 : (e_dg ? 2 : 0);
      m_err  = e_oor;
      m_data = (!e_req || e_we) ? 32'h0 : model_mem[w];
      if (e_we)
        for (int b = 0; b < 4; b++)
          if (data_be_i[b]) model_mem[w][8*b +: 8] = data_wdata_i[8*b +: 8];
      if (!instr_req_i || e_ig) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
  endtask

  logic [9:0] gv, dv, gexp;

  initial begin
    for (int i = 0; i < SIZE_WORDS; i++) begin
      ram_mem[i]   = 32'hA5000000 ^ 32'(i);
      model_mem[i] = 32'hA5000000 ^ 32'(i);
    end
    ram_mem[4] = 32'h00500093; model_mem[4] = 32'h00500093;
    ram_mem[8] = 32'h11223344; model_mem[8] = 32'h11223344;

    rst = 1'b1;
    instr_addr_i = '0; data_addr_i = '0; data_wdata_i = '0; data_be_i = '0;
    idle();
    step(); step();
    rst = 1'b0;

    // Instruction fetch alone
    instr_req_i = 1'b1; instr_addr_i = 32'h10;
    @(negedge clk); chk("t1_gnt", {31'b0, instr_gnt_o}, 1);
    step(); idle();
    @(negedge clk);
    chk("t1_rv", {31'b0, instr_rvalid_o}, 1);
    chk("t1_rdata", instr_rdata_o, 32'h00500093);
    chk("t1_err", {31'b0, instr_err_o}, 0);

    // Partial store then load of the same word
    step();
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h20;
    data_wdata_i = 32'hDEADBEEF; data_be_i = 4'b0011;
    step(); data_we_i = 1'b0; data_be_i = 4'hF;
    @(negedge clk);
    chk("t2_st_rv", {31'b0, data_rvalid_o}, 1);
    chk("t2_st_rdata", data_rdata_o, 0);
    step(); idle();
    @(negedge clk);
    chk("t2_ld_rdata", data_rdata_o, 32'h1122BEEF);

    // Continuous contention: starvation guard every MAX_WAIT+1 cycles
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h40;
    data_req_i = 1'b1; data_addr_i = 32'h44;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gv[i] = instr_gnt_o;
      dv[i] = data_gnt_o;
      if (i < 9) step();
    end
    gexp = 10'b10_0001_0000;
    chk("t3_igrants", {22'b0, gv}, {22'b0, gexp});
    chk("t3_dgrants", {22'b0, dv}, {22'b0, ~gexp});
    step(); idle();

    // Out-of-range load and store, plus an out-of-range fetch
    step();
    data_req_i = 1'b1; data_addr_i = 32'h1000;
    @(negedge clk);
    chk("t4_ramreq", {31'b0, ram_req_o}, 0);
    step();
    data_we_i = 1'b1; data_wdata_i = 32'hFFFFFFFF; data_be_i = 4'hF;
    @(negedge clk);
    chk("t4_rv", {31'b0, data_rvalid_o}, 1);
    chk("t4_err", {31'b0, data_err_o}, 1);
    chk("t4_rdata", data_rdata_o, 0);
    step(); idle();
    instr_req_i = 1'b1; instr_addr_i = 32'hFFFFFFFC;
    step(); idle();
    @(negedge clk);
    chk("t4_ierr", {31'b0, instr_err_o}, 1);
    chk("t4_nomod", ram_mem[0], 32'hA5000000);

    // Mixed back-to-back traffic from a deterministic pattern
    for (int i = 0; i < 24; i++) begin
      step();
      instr_req_i  = (i % 3) != 0;
      instr_addr_i = (i == 7) ? 32'h2000 : 32'(4 * (i % 12));
      data_req_i   = (i % 2) == 0;
      data_we_i    = (i % 4) == 0;
      data_addr_i  = (i == 10) ? 32'h0FFF_FFF0 : 32'(4 * ((i * 5) % 16));
      data_wdata_i = 32'hC0DE0000 + 32'(i);
      data_be_i    = 4'(i + 1);
    end
    step(); idle();

    // Reset while a fetch response is pending, then a stray RAM rvalid
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h10;
    step(); idle(); rst = 1'b1;
    @(negedge clk);
    chk("t5_rv_in_rst", {31'b0, instr_rvalid_o}, 0);
    step(); rst = 1'b0; spur = 1'b1;
    @(negedge clk);
    chk("t5_spur_irv", {31'b0, instr_rvalid_o}, 0);
    chk("t5_spur_drv", {31'b0, data_rvalid_o}, 0);
    step(); spur = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency, rvalid one cycle after req) between the CV32E40P instruction and data OBI ports.
- Grants at most one master per cycle and records the owner of each in-flight access, so responses return to the correct master.
- Data port has priority by default; a starvation counter protects instruction fetch.
- Out-of-range accesses complete locally with an error instead of aliasing in RAM.

Parameters:
- SIZE_WORDS, 1024, RAM depth in 32-bit words; the valid byte range is 0 .. 4*SIZE_WORDS-1.
- MAX_WAIT, 4, consecutive denied instruction cycles before instruction gets priority (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- instr_req_i  in  1  fetch request
- instr_addr_i  in  32  fetch byte address
- instr_gnt_o  out  1  fetch accepted this cycle (combinational)
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  32  fetch data
- instr_err_o  out  1  fetch out of range, qualified by rvalid
- data_req_i  in  1  load/store request
- data_we_i  in  1  1 = store
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  store data
- data_be_i  in  4  byte enables
- data_gnt_o  out  1  load/store accepted (combinational)
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  load data
- data_err_o  out  1  out of range, qualified by rvalid
- ram_req_o  out  1  RAM request
- ram_we_o  out  1  RAM write
- ram_addr_o  out  32  RAM byte address
- ram_wdata_o  out  32  RAM write data
- ram_be_o  out  4  RAM byte enables
- ram_rdata_i  in  32  RAM read data
- ram_rvalid_i  in  1  RAM response valid

Behaviour:
- Reset (async, rst=1):
  - owner_q=NONE, wait_q=0.
  - All rvalid/err outputs 0, rdata outputs 0.
  - Grants and ram_req_o are 0 while rst is high.
  - The top level drives the RAM reset as ~rst.
- Arbitration (combinational, same cycle as req):
  - Only one master requests: it is granted.
  - Both request: data wins, unless wait_q==MAX_WAIT, in which case instr wins.
  - No request: no grant, ram_req_o=0, all ram_* outputs 0.
  - Back-to-back grants every cycle are allowed; the RAM accepts one access per cycle.
- Starvation counter wait_q (4 bits):
  - Increments, saturating at MAX_WAIT, each cycle instr_req_i=1 and instr_gnt_o=0.
  - Clears on an instr grant, or when instr_req_i=0.
- Range check: out of range when addr[31:2] >= SIZE_WORDS.
- Granted in-range access:
  - ram_req_o=1, address passed through.
  - Instr grant forces ram_we_o=0, ram_be_o=4'hF, ram_wdata_o=0.
- Granted out-of-range access:
  - ram_req_o=0; a store is dropped (no memory change).
- Owner pipeline: on each grant, register owner_q (INSTR/DATA), oor_q and we_q; otherwise owner_q=NONE. Response lands exactly one cycle after the grant.
- Response routing, cycle after grant:
  - In range: owner's rvalid=1 (taken from ram_rvalid_i), rdata=ram_rdata_i; store responses force rdata=0.
  - Out of range: owner's rvalid=1, rdata=0, err=1.
  - The non-owner's rvalid=0 and rdata holds its last value.
- ram_rvalid_i while owner_q=NONE: ignored.
- Reset mid-operation discards any pending response; no rvalid is issued after reset release for a pre-reset grant.
- Latency: grant to rvalid = 1 cycle for both masters; sustained throughput 1 access per cycle total.

Decomposition:
- Package ram_arb_pkg:
  - owner_e enum {OWN_NONE, OWN_INSTR, OWN_DATA} (2 bits).
  - RAM_BE_FULL=4'hF.
  - Localparam widths for wait_q.
- No sub-module is needed. Arbitration, counter and response mux fit in one module (~150–200 lines).

Test Plan:
- Instr only: fetch at addr 0x10, RAM word 4 = 0x00500093 → instr_gnt_o same cycle; next cycle instr_rvalid_o=1, instr_rdata_o=0x00500093, instr_err_o=0.
- Store then load: store 0xDEADBEEF, be=4'b0011, addr 0x20 (old word 0x11223344); then load 0x20 → store rvalid with rdata 0; load returns 0x1122BEEF.
- Contention, MAX_WAIT=4: both request continuously → data granted cycles 0–3, instr granted cycle 4, wait_q back to 0; rvalids alternate to the correct owner with no cross-delivery.
- Out of range: load addr 0x1000 with SIZE_WORDS=1024 → ram_req_o=0; next cycle data_rvalid_o=1, data_err_o=1, data_rdata_o=0. Store to 0x1000 leaves RAM unchanged.
- Reset mid-access: grant instr, assert rst in the following cycle before rvalid → instr_rvalid_o=0; after release, owner_q=NONE and a spurious ram_rvalid_i=1 produces no rvalid.
